// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, one shared carry flop.
// Results are published atomically on the last RUN edge; sum/cout/ovf are never partial.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is sampled only in IDLE; busy is high from the capture edge
  // until the last-bit edge, where done pulses for exactly one cycle.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, msba, msbb;
  logic             s, c_nxt, last;

  assign s       = opa[0] ^ opb[0] ^ carry;
  assign c_nxt   = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
  assign acc_nxt = WIDTH'({s, acc} >> 1);
  assign last    = (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      msba  <= 1'b0;
      msbb  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 rides in as the initial carry.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            acc   <= '0;
            msba  <= a[WIDTH-1];
            msbb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            busy  <= 1'b1;
          end
        end
        RUN: begin
          carry <= c_nxt;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= acc_nxt;
            cout <= c_nxt;
            ovf  <= (msba == msbb) && (s != msba);
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
